data_rx: RTL

- Receive-direction counterpart of data_tx. Parses server-to-client frames delivered byte-by-byte by the network receive engine.
- Validates each frame's header, length and XOR checksum.
- Drives the client's connection status and streams display-update bytes to the display buffer write port.
- Sits between the rx engine and the display/status logic, parallel to data_tx on the transmit side.

---
 rtl/data_rx_if.sv | 29 ++
 rtl/data_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/data_rx_if.sv
// data_rx bus: rx byte stream in, display write port and status out.
// The DUT side takes the slave view; the rx engine / bench take the master view.
interface data_rx_if #(
  parameter int ADDR_W = 11
) ();
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_sof;
  logic              rx_eof;
  logic              online;
  logic [7:0]        disp_data;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_we;
  logic              pkt_ok;
  logic              pkt_err;
  logic              busy;

  modport master (
    output rx_data, rx_valid, rx_sof, rx_eof,
    input  online, disp_data, disp_addr, disp_we,
    input  pkt_ok, pkt_err, busy
  );

  modport slave (
    input  rx_data, rx_valid, rx_sof, rx_eof,
    output online, disp_data, disp_addr, disp_we,
    output pkt_ok, pkt_err, busy
  );
endinterface

// File: rtl/data_rx.sv
// Server-to-client frame parser: TYPE, LEN, payload, XOR checksum.
// Tracks connection status and streams DISPLAY payload to the display buffer.
module data_rx #(
  parameter int MAX_LEN = 64,
  parameter int ADDR_W  = 11
) (
  input logic       clk,
  input logic       reset,
  data_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAY,
    S_CSUM,
    S_DROP
  } state_t;

  localparam logic [7:0] T_ACK  = 8'h01;
  localparam logic [7:0] T_DISC = 8'h02;
  localparam logic [7:0] T_DISP = 8'h10;
  localparam logic [7:0] MAXL   = 8'(MAX_LEN);

  state_t            state;
  logic [7:0]        typ;
  logic [7:0]        len;
  logic [7:0]        cnt;
  logic [7:0]        acc;
  logic [7:0]        hi;
  logic              online;
  logic [7:0]        disp_data;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_we;
  logic              pkt_ok;
  logic              pkt_err;
  logic              len_bad;

  logic [7:0] d;
  logic       v;
  logic       sof;
  logic       eof;

  assign d   = bus.rx_data;
  assign v   = bus.rx_valid;
  assign sof = bus.rx_sof;
  assign eof = bus.rx_eof;

  always_comb begin
    len_bad = 1'b1;
    unique case (1'b1)
      (typ == T_ACK),
      (typ == T_DISC): len_bad = (d != 8'd0);
      (typ == T_DISP): len_bad = (d < 8'd2) || (d > MAXL);
      default:         len_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      typ       <= '0;
      len       <= '0;
      cnt       <= '0;
      acc       <= '0;
      hi        <= '0;
      online    <= 1'b0;
      disp_data <= '0;
      disp_addr <= '0;
      disp_we   <= 1'b0;
      pkt_ok    <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      pkt_ok  <= 1'b0;
      pkt_err <= 1'b0;
      disp_we <= 1'b0;
      // Address advances once the write it belongs to has been presented
      if (disp_we)
        disp_addr <= disp_addr + ADDR_W'(1);
      if (v) begin
        if (sof) begin
          // A DROP frame was already reported; only a live frame gets an abort error
          pkt_err <= eof || (state != S_IDLE && state != S_DROP);
          typ     <= d;
          acc     <= d;
          cnt     <= '0;
          state   <= eof ? S_IDLE : S_LEN;
        end else begin
          unique case (state)
            S_IDLE: ;
            S_LEN: begin
              len <= d;
              acc <= acc ^ d;
              if (eof) begin
                pkt_err <= 1'b1;
                state   <= S_IDLE;
              end else if (len_bad) begin
                pkt_err <= 1'b1;
                state   <= S_DROP;
              end else begin
                state <= (d != 8'd0) ? S_PAY : S_CSUM;
              end
            end
            S_PAY: begin
              acc <= acc ^ d;
              cnt <= cnt + 8'd1;
              if (eof) begin
                pkt_err <= 1'b1;
                state   <= S_IDLE;
              end else begin
                if (typ == T_DISP) begin
                  if (cnt == 8'd0) begin
                    hi <= d;
                  end else if (cnt == 8'd1) begin
                    disp_addr <= ADDR_W'({hi, d});
                  end else begin
                    disp_we   <= 1'b1;
                    disp_data <= d;
                  end
                end
                if (cnt == len - 8'd1)
                  state <= S_CSUM;
              end
            end
            S_CSUM: begin
              if (eof && d == acc) begin
                pkt_ok <= 1'b1;
                if (typ == T_ACK)
                  online <= 1'b1;
                if (typ == T_DISC)
                  online <= 1'b0;
                state <= S_IDLE;
              end else begin
                pkt_err <= 1'b1;
                state   <= eof ? S_IDLE : S_DROP;
              end
            end
            S_DROP: begin
              if (eof)
                state <= S_IDLE;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  assign bus.online    = online;
  assign bus.disp_data = disp_data;
  assign bus.disp_addr = disp_addr;
  assign bus.disp_we   = disp_we;
  assign bus.pkt_ok    = pkt_ok;
  assign bus.pkt_err   = pkt_err;
  assign bus.busy      = (state != S_IDLE);

endmodule
